// File: rtl/bsg_manycore_io_concentrator_if.sv
// bsg_manycore_io_concentrator_if: valid/ready bundle of n_p lanes, each width_p bits wide.
// Ports (signals):
//   v     : per-lane valid, driven by the master
//   data  : lane-packed payload, lane i at [i*width_p +: width_p], driven by the master
//   ready : per-lane accept, driven by the slave
// A transfer happens on lane i when v[i] & ready[i] at a rising clock edge.
interface bsg_manycore_io_concentrator_if #(
  parameter int n_p     = 1,
  parameter int width_p = 64
);
  logic [n_p-1:0]         v;
  logic [n_p*width_p-1:0] data;
  logic [n_p-1:0]         ready;
  modport master (output v, output data, input ready);
  modport slave  (input v, input data, output ready);
endinterface

// File: rtl/bsg_manycore_io_concentrator.sv
// bsg_manycore_io_concentrator: concentrates num_cols_p column IO links onto num_chan_p channels.
// Column c is served by channel c % num_chan_p through a round-robin arbiter and a request FIFO.
// Returns go through a per-channel FIFO and are routed to the column named by the x field;
// packets naming a column outside the channel's group are dropped and flagged in err_o.
// Ports:
//   clk_i        : clock
//   reset_n_i    : asynchronous active-low reset
//   col_req_i    : column requests in (slave, num_cols_p lanes)
//   col_ret_o    : returns to columns (master, num_cols_p lanes)
//   chan_req_o   : requests to channels (master, num_chan_p lanes)
//   chan_ret_i   : returns from channels (slave, num_chan_p lanes)
//   reset_o      : synchronised active-high reset for the tile array
//   err_o        : sticky per-channel misroute flag
// Optional (macro BSG_MANYCORE_IO_CONC_STATS_EN):
//   stat_req_cnt_o  : per-channel 32-bit count of requests sent to the channel
//   stat_drop_cnt_o : per-channel 16-bit count of dropped returns
module bsg_manycore_io_conc_fifo #(
  parameter int els_p   = 2,
  parameter int width_p = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int aw_lp = els_p > 1 ? $clog2(els_p) : 1;
  localparam int cw_lp = $clog2(els_p + 1);
  logic [width_p-1:0] mem_q [els_p];
  logic [aw_lp-1:0]   wptr_q, rptr_q;
  logic [cw_lp-1:0]   cnt_q;
  always_ff @(posedge clk_i) begin
    if (enq_i) mem_q[wptr_q] <= data_i;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (enq_i) wptr_q <= wptr_q == aw_lp'(els_p - 1) ? '0 : wptr_q + aw_lp'(1);
      if (deq_i) rptr_q <= rptr_q == aw_lp'(els_p - 1) ? '0 : rptr_q + aw_lp'(1);
      cnt_q <= cnt_q + cw_lp'(enq_i) - cw_lp'(deq_i);
    end
  end
  assign data_o  = mem_q[rptr_q];
  assign full_o  = cnt_q == cw_lp'(els_p);
  assign empty_o = cnt_q == '0;
endmodule

module bsg_manycore_io_concentrator #(
  parameter int num_cols_p     = 4,
  parameter int num_chan_p     = 2,
  parameter int width_p        = 64,
  parameter int x_lsb_p        = 0,
  parameter int x_width_p      = 2,
  parameter int fifo_els_p     = 2,
  parameter int reset_stages_p = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  bsg_manycore_io_concentrator_if.slave  col_req_i,
  bsg_manycore_io_concentrator_if.master col_ret_o,
  bsg_manycore_io_concentrator_if.master chan_req_o,
  bsg_manycore_io_concentrator_if.slave  chan_ret_i,
  output logic                     reset_o,
  output logic [num_chan_p-1:0]    err_o
`ifdef BSG_MANYCORE_IO_CONC_STATS_EN
  ,
  output logic [num_chan_p*32-1:0] stat_req_cnt_o,
  output logic [num_chan_p*16-1:0] stat_drop_cnt_o
`endif
);
  localparam int grp_lp   = num_cols_p / num_chan_p;
  localparam int ptr_w_lp = grp_lp > 1 ? $clog2(grp_lp) : 1;

  logic rst;

  // Reset asserts as soon as reset_n_i falls and is released through a flop chain.
  if (reset_stages_p == 0) begin : g_raw
    assign rst = ~reset_n_i;
  end else begin : g_sync
    logic [reset_stages_p-1:0] sync_q;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) sync_q <= '1;
      else            sync_q <= sync_q << 1;
    end
    assign rst = sync_q[reset_stages_p-1];
  end
  assign reset_o = rst;

  logic [num_chan_p-1:0] req_enq, ret_v;
  int                    req_gi   [num_chan_p];
  logic [31:0]           ret_x    [num_chan_p];
  logic [width_p-1:0]    ret_data [num_chan_p];

  for (genvar k = 0; k < num_chan_p; k++) begin : ch
    logic [ptr_w_lp-1:0] ptr_q, ptr_d;
    logic                lo_f, hi_f, found;
    int                  lo, hi, gi;
    logic [width_p-1:0]  req_data, req_head, ret_head;
    logic                req_full, req_empty, req_deq;
    logic                ret_full, ret_empty, ret_enq, ret_deq, ret_rdy;
    logic                ok, sel_rdy, drop, err_q;
    logic [31:0]         x;
    // Members are scanned high to low so the last hit is the lowest; hi tracks the
    // lowest valid member at or after the pointer, lo the lowest overall (wrap case).
    always_comb begin
      lo_f = 1'b0;
      hi_f = 1'b0;
      lo   = 0;
      hi   = 0;
      for (int m = grp_lp - 1; m >= 0; m--) begin
        if (col_req_i.v[m*num_chan_p+k]) begin
          lo_f = 1'b1;
          lo   = m;
          if (m >= int'(ptr_q)) begin
            hi_f = 1'b1;
            hi   = m;
          end
        end
      end
      found = lo_f;
      gi    = hi_f ? hi : lo;
    end
    always_comb begin
      req_data = '0;
      for (int m = 0; m < grp_lp; m++)
        if (gi == m) req_data = col_req_i.data[(m*num_chan_p+k)*width_p +: width_p];
    end
    assign req_deq    = ~req_empty & chan_req_o.ready[k];
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign req_enq[k] = found & ~rst & (~req_full | req_deq);
    assign req_gi[k]  = gi;
    assign ptr_d      = req_enq[k] ? (gi == grp_lp - 1 ? '0 : ptr_w_lp'(gi + 1)) : ptr_q;
    always_ff @(posedge clk_i or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
    end
    bsg_manycore_io_conc_fifo #(.els_p(fifo_els_p), .width_p(width_p)) req_fifo (
      .clk_i, .rst_i(rst), .enq_i(req_enq[k]), .data_i(req_data), .deq_i(req_deq),
      .data_o(req_head), .full_o(req_full), .empty_o(req_empty)
    );
    assign chan_req_o.v[k]                          = ~req_empty;
    assign chan_req_o.data[k*width_p +: width_p]    = req_head;

    bsg_manycore_io_conc_fifo #(.els_p(fifo_els_p), .width_p(width_p)) ret_fifo (
      .clk_i, .rst_i(rst), .enq_i(ret_enq), .data_i(chan_ret_i.data[k*width_p +: width_p]),
      .deq_i(ret_deq), .data_o(ret_head), .full_o(ret_full), .empty_o(ret_empty)
    );
    assign x  = 32'(ret_head[x_lsb_p +: x_width_p]);
    assign ok = (x < 32'(num_cols_p)) && (x % 32'(num_chan_p) == 32'(k));
    always_comb begin
      sel_rdy = 1'b0;
      for (int m = 0; m < grp_lp; m++)
        if (x == 32'(m*num_chan_p + k)) sel_rdy = col_ret_o.ready[m*num_chan_p+k];
    end
    // Misrouted heads are discarded immediately so they never block the channel.
    assign drop               = ~ret_empty & ~ok;
    assign ret_v[k]           = ~ret_empty & ok;
    assign ret_deq            = drop | (ret_v[k] & sel_rdy);
    assign ret_rdy            = ~rst & (~ret_full | ret_deq);
    assign ret_enq            = chan_ret_i.v[k] & ret_rdy;
    assign chan_ret_i.ready[k] = ret_rdy;
    assign ret_x[k]           = x;
    assign ret_data[k]        = ret_head;
    always_ff @(posedge clk_i or posedge rst) begin
      if (rst)       err_q <= 1'b0;
      else if (drop) err_q <= 1'b1;
    end
    assign err_o[k] = err_q;
`ifdef BSG_MANYCORE_IO_CONC_STATS_EN
    logic [31:0] req_cnt_q;
    logic [15:0] drop_cnt_q;
    always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
        req_cnt_q  <= '0;
        drop_cnt_q <= '0;
      end else begin
        if (req_deq) req_cnt_q  <= req_cnt_q + 32'd1;
        if (drop)    drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
    assign stat_req_cnt_o[k*32 +: 32]  = req_cnt_q;
    assign stat_drop_cnt_o[k*16 +: 16] = drop_cnt_q;
`endif
  end

  // Each column belongs to exactly one channel, so its outputs come from that channel alone.
  for (genvar c = 0; c < num_cols_p; c++) begin : col
    localparam int k_lp = c % num_chan_p;
    assign col_req_i.ready[c]                   = req_enq[k_lp] & (req_gi[k_lp] == c / num_chan_p);
    assign col_ret_o.v[c]                       = ret_v[k_lp] & (ret_x[k_lp] == 32'(c));
    assign col_ret_o.data[c*width_p +: width_p] = ret_data[k_lp];
  end
endmodule
